// File: rtl/uart_rx_pkg.sv
// Shared constants and types for the memory-mapped UART receiver.
package uart_rx_pkg;

  localparam logic [3:0] OFF_RXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;

  localparam int ST_NOT_EMPTY  = 0;
  localparam int ST_FULL       = 1;
  localparam int ST_OVERFLOW   = 2;
  localparam int ST_FRAME_ERR  = 3;
  localparam int ST_PARITY_ERR = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO; a push into a full FIFO lands only if a pop frees a slot in the same cycle.
module uart_rx_fifo #(
  parameter int Width = 8,
  parameter int Depth = 8
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW:0]      wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_dev.sv
// Memory-mapped 8N1 UART receiver with byte FIFO and level IRQ.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity errors.
module uart_rx_dev
  import uart_rx_pkg::*;
#(
  parameter int ClockFrequency = 50_000_000,
  parameter int BaudRate       = 115200,
  parameter int FifoDepth      = 8
) (
  input  logic        clk_sys_i,
  input  logic        rst_sys_ni,
  input  logic        device_req_i,
  input  logic [31:0] device_addr_i,
  input  logic        device_we_i,
  input  logic [3:0]  device_be_i,
  input  logic [31:0] device_wdata_i,
  output logic        device_rvalid_o,
  output logic [31:0] device_rdata_o,
  input  logic        uart_rx_i,
  output logic        rx_irq_o
);
  localparam int BitDiv = ClockFrequency / BaudRate;
  localparam int CntW   = $clog2(BitDiv);
  localparam logic [CntW-1:0] HalfLoad = CntW'(BitDiv / 2 - 1);
  localparam logic [CntW-1:0] FullLoad = CntW'(BitDiv - 1);

  logic            sync1_q, sync2_q, prev_q;
  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            tick, push, frame_set;
`ifdef UART_RX_PARITY_EN
  logic            par_q, par_d, par_set, par_err_q;
`endif

  logic        rd_en, wr_en, sel_rx, sel_st, sel_ctrl, pop, ovf_set;
  logic [4:0]  clr;
  logic [7:0]  fifo_rdata;
  logic        fifo_empty, fifo_full;
  logic        ovf_q, frm_q, irq_en_q, irq_q, rvalid_q;
  logic [31:0] rdata_q, rdata_d, status;
  logic        unused_bits;

  // The line idles high, so the synchroniser resets to 1 to avoid a fake start edge.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= uart_rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    push      = 1'b0;
    frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
    par_set   = 1'b0;
`endif
    if (state_q != IDLE && !tick) cnt_d = cnt_q - 1'b1;
    case (state_q)
      IDLE: begin
        // Half-bit load puts every later sample at the bit centre.
        if (prev_q && !sync2_q) begin
          state_d = START;
          cnt_d   = HalfLoad;
        end
      end
      START: begin
        if (tick) begin
          if (!sync2_q) begin
            state_d = DATA;
            bit_d   = '0;
            cnt_d   = FullLoad;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shreg_d = {sync2_q, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          cnt_d   = FullLoad;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          par_d   = sync2_q;
          cnt_d   = FullLoad;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          if (!sync2_q) frame_set = 1'b1;
`ifdef UART_RX_PARITY_EN
          else if (par_q != ^shreg_q) par_set = 1'b1;
`endif
          else push = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  uart_rx_fifo #(
    .Width(8),
    .Depth(FifoDepth)
  ) u_fifo (
    .clk_sys_i (clk_sys_i),
    .rst_sys_ni(rst_sys_ni),
    .push_i    (push),
    .pop_i     (pop),
    .wdata_i   (shreg_q),
    .rdata_o   (fifo_rdata),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full)
  );

  assign rd_en    = device_req_i & ~device_we_i;
  assign wr_en    = device_req_i & device_we_i & device_be_i[0];
  assign sel_rx   = (device_addr_i[3:2] == OFF_RXDATA[3:2]);
  assign sel_st   = (device_addr_i[3:2] == OFF_STATUS[3:2]);
  assign sel_ctrl = (device_addr_i[3:2] == OFF_CTRL[3:2]);
  assign pop      = rd_en & sel_rx;
  assign ovf_set  = push & fifo_full & ~pop;
  assign clr      = (wr_en && sel_st) ? device_wdata_i[4:0] : 5'b0;

  always_comb begin
    status               = '0;
    status[ST_NOT_EMPTY] = ~fifo_empty;
    status[ST_FULL]      = fifo_full;
    status[ST_OVERFLOW]  = ovf_q;
    status[ST_FRAME_ERR] = frm_q;
`ifdef UART_RX_PARITY_EN
    status[ST_PARITY_ERR] = par_err_q;
`endif
    rdata_d = '0;
    if (rd_en) begin
      if (sel_rx && !fifo_empty) rdata_d = {24'b0, fifo_rdata};
      else if (sel_st)           rdata_d = status;
      else if (sel_ctrl)         rdata_d = {31'b0, irq_en_q};
    end
  end

  // Sticky flags: a set in the same cycle as a W1C clear wins.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
      irq_en_q  <= 1'b0;
      ovf_q     <= 1'b0;
      frm_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      rvalid_q  <= device_req_i;
      rdata_q   <= rdata_d;
      irq_q     <= irq_en_q & ~fifo_empty;
      ovf_q     <= ovf_set | (ovf_q & ~clr[ST_OVERFLOW]);
      frm_q     <= frame_set | (frm_q & ~clr[ST_FRAME_ERR]);
`ifdef UART_RX_PARITY_EN
      par_err_q <= par_set | (par_err_q & ~clr[ST_PARITY_ERR]);
`endif
      if (wr_en && sel_ctrl) irq_en_q <= device_wdata_i[0];
    end
  end

  assign device_rvalid_o = rvalid_q;
  assign device_rdata_o  = rdata_q;
  assign rx_irq_o        = irq_q;

`ifdef UART_RX_PARITY_EN
  assign unused_bits = ^{device_addr_i[31:4], device_addr_i[1:0], device_be_i[3:1],
                         device_wdata_i[31:5]};
`else
  assign unused_bits = ^{device_addr_i[31:4], device_addr_i[1:0], device_be_i[3:1],
                         device_wdata_i[31:5], clr[ST_PARITY_ERR]};
`endif

endmodule

// File: tb/tb_uart_rx_dev.sv
// Bench for uart_rx_dev: frame-level reference model plus directed register checks.
`timescale 1ns/1ps
module tb_uart_rx_dev;
  localparam int DEPTH = 8;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 108;
`else
  localparam int LAT = 98;
`endif
  localparam int K_OK = 0, K_FRAME = 1, K_PAR = 2;

  logic        clk = 1'b0, rst_ni = 1'b1;
  logic        req = 1'b0, we = 1'b0, rx_line = 1'b1;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  be = '0;
  logic        rvalid, irq;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  uart_rx_dev #(
    .ClockFrequency(1_000_000),
    .BaudRate      (100_000),
    .FifoDepth     (DEPTH)
  ) dut (
    .clk_sys_i      (clk),
    .rst_sys_ni     (rst_ni),
    .device_req_i   (req),
    .device_addr_i  (addr),
    .device_we_i    (we),
    .device_be_i    (be),
    .device_wdata_i (wdata),
    .device_rvalid_o(rvalid),
    .device_rdata_o (rdata),
    .uart_rx_i      (rx_line),
    .rx_irq_o       (irq)
  );

  int total = 0, bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: byte queue, sticky flags, scheduled frame outcomes.
  typedef struct {
    int         c;
    logic [7:0] b;
    int         kind;
  } ev_t;

  int          cyc = 0;
  int          last_push = 0;
  ev_t         sched[$];
  logic [7:0]  q[$];
  logic        m_ovf = 0, m_frm = 0, m_par = 0, m_irq_en = 0;
  logic        exp_rv = 0, exp_irq = 0;
  logic [31:0] exp_rd = '0;

  always @(posedge clk) begin
    logic [31:0] rd_n;
    logic        irq_n, pop_n;
    ev_t         e;
    cyc++;
    if (!rst_ni) begin
      q.delete();
      m_ovf = 0; m_frm = 0; m_par = 0; m_irq_en = 0;
      exp_rv = 0; exp_rd = '0; exp_irq = 0;
    end else begin
      irq_n = m_irq_en && (q.size() != 0);
      rd_n  = '0;
      pop_n = 0;
      if (req && !we) begin
        case (addr[3:2])
          2'd0: if (q.size() != 0) begin rd_n = {24'd0, q[0]}; pop_n = 1; end
          2'd1: rd_n = {27'd0, m_par, m_frm, m_ovf, q.size() == DEPTH, q.size() != 0};
          2'd2: rd_n = {31'd0, m_irq_en};
          default: rd_n = '0;
        endcase
      end
      if (req && we && be[0]) begin
        if (addr[3:2] == 2'd1) begin
          if (wdata[2]) m_ovf = 0;
          if (wdata[3]) m_frm = 0;
          if (wdata[4]) m_par = 0;
        end else if (addr[3:2] == 2'd2) begin
          m_irq_en = wdata[0];
        end
      end
      if (pop_n) void'(q.pop_front());
      while (sched.size() != 0 && sched[0].c == cyc) begin
        e = sched.pop_front();
        if (e.kind == K_FRAME) m_frm = 1;
        else if (e.kind == K_PAR) m_par = 1;
        else if (q.size() < DEPTH) q.push_back(e.b);
        else m_ovf = 1;
      end
      exp_rv  = req;
      exp_rd  = rd_n;
      exp_irq = irq_n;
    end
  end

  always @(negedge clk) begin
    if (rst_ni) begin
      check("rvalid", {31'd0, rvalid}, {31'd0, exp_rv});
      if (exp_rv) check("rdata", rdata, exp_rd);
      check("irq", {31'd0, irq}, {31'd0, exp_irq});
    end
  end

  task automatic send(input logic [7:0] b, input int kind);
    ev_t e;
    @(negedge clk);
    rx_line = 1'b0;
    e.c = cyc + LAT; e.b = b; e.kind = kind;
    sched.push_back(e);
    last_push = e.c;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      repeat (10) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx_line = (kind == K_PAR) ? ~(^b) : ^b;
    repeat (10) @(negedge clk);
`endif
    rx_line = (kind == K_FRAME) ? 1'b0 : 1'b1;
    repeat (10) @(negedge clk);
    rx_line = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic bus(input logic w, input logic [3:0] off, input logic [31:0] d,
                     input logic [3:0] bes, output logic [31:0] r);
    @(negedge clk);
    req = 1'b1; we = w; addr = {28'd0, off}; wdata = d; be = bes;
    @(negedge clk);
    req = 1'b0; we = 1'b0; be = '0;
    r = rdata;
  endtask

  task automatic rd_chk(input string n, input logic [3:0] off, input logic [31:0] exp);
    logic [31:0] r;
    bus(1'b0, off, '0, 4'hF, r);
    check(n, r, exp);
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d, input logic [3:0] bes);
    logic [31:0] r;
    bus(1'b1, off, d, bes, r);
  endtask

  initial begin
    int t;
    #2 rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk);
    rd_chk("rst_status", 4'h4, 32'h0);
    rd_chk("rst_ctrl", 4'h8, 32'h0);

    send(8'hA5, K_OK);
    rd_chk("a5_status", 4'h4, 32'h1);
    rd_chk("a5_data", 4'h0, 32'hA5);
    rd_chk("a5_status_after", 4'h4, 32'h0);
    rd_chk("empty_read", 4'h0, 32'h0);
    rd_chk("unmapped", 4'hC, 32'h0);

    @(negedge clk); rx_line = 1'b0;
    repeat (3) @(negedge clk); rx_line = 1'b1;
    repeat (25) @(negedge clk);
    rd_chk("glitch_status", 4'h4, 32'h0);

    send(8'h3C, K_FRAME);
    rd_chk("frame_status", 4'h4, 32'h8);
    wr(4'h4, 32'h8, 4'hF);
    rd_chk("frame_cleared", 4'h4, 32'h0);

    for (int i = 1; i <= 9; i++) send(8'(i), K_OK);
    rd_chk("ovf_status", 4'h4, 32'h7);
    for (int i = 1; i <= 8; i++) rd_chk("ovf_data", 4'h0, 32'(i));
    rd_chk("ovf_ninth", 4'h0, 32'h0);
    rd_chk("ovf_sticky", 4'h4, 32'h4);
    wr(4'h4, 32'h4, 4'hF);
    rd_chk("ovf_cleared", 4'h4, 32'h0);

    // Ninth push lands in the same cycle as a pop of the full FIFO.
    for (int i = 1; i <= 8; i++) send(8'(i), K_OK);
    fork
      send(8'h09, K_OK);
      begin
        logic [31:0] r;
        repeat (2) @(negedge clk);
        t = last_push;
        while (cyc < t - 2) @(negedge clk);
        bus(1'b0, 4'h0, '0, 4'hF, r);
        check("fullpop_data", r, 32'h01);
      end
    join
    rd_chk("fullpop_status", 4'h4, 32'h3);
    for (int i = 2; i <= 9; i++) rd_chk("fullpop_data", 4'h0, 32'(i));
    rd_chk("fullpop_empty", 4'h4, 32'h0);

    wr(4'h8, 32'h1, 4'hE);
    rd_chk("ctrl_be_gated", 4'h8, 32'h0);
    wr(4'h8, 32'h1, 4'hF);
    rd_chk("ctrl_set", 4'h8, 32'h1);
    fork
      send(8'h55, K_OK);
      begin
        repeat (2) @(negedge clk);
        t = last_push;
        while (cyc < t) @(negedge clk);
        check("irq_lag", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("irq_rise", {31'd0, irq}, 32'd1);
      end
    join
    rd_chk("irq_data", 4'h0, 32'h55);
    check("irq_hold", {31'd0, irq}, 32'd1);
    @(negedge clk);
    check("irq_fall", {31'd0, irq}, 32'd0);
    wr(4'h8, 32'h0, 4'hF);
    send(8'h55, K_OK);
    check("irq_masked", {31'd0, irq}, 32'd0);
    rd_chk("masked_data", 4'h0, 32'h55);

`ifdef UART_RX_PARITY_EN
    send(8'h07, K_PAR);
    rd_chk("par_status", 4'h4, 32'h10);
    wr(4'h4, 32'h10, 4'hF);
    rd_chk("par_cleared", 4'h4, 32'h0);
    send(8'h07, K_OK);
    rd_chk("par_good", 4'h0, 32'h07);
`endif

    repeat (5) @(negedge clk);
    check("sched_drained", 32'(sched.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
